// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter / rotator with valid-ready handshake on both sides.
// One register stage per shift-amount bit: stage k applies a shift of 2^k when
// its amount bit is set. The whole pipe advances together; a stalled output
// freezes every stage.
module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero
);

    localparam int SW = $clog2(WIDTH);
    localparam int S  = SW;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;

    // Shift by a fixed power of two. SAR fills from the carried original MSB,
    // so cascading right shifts still replicate the operand's sign.
    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input int               sh
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
        case (mode)
            MODE_ROL: res = (d << sh) | (d >> (WIDTH - sh));
            MODE_ROR: res = (d >> sh) | (d << (WIDTH - sh));
            MODE_SHL: res = d << sh;
            default:  res = (d >> sh) | fill;
        endcase
        return res;
    endfunction

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < S; k++) begin : g_stage
        // Remaining amount bits entering this stage; bit 0 selects this stage's shift.
        localparam int AW = SW - k;

        logic [WIDTH-1:0] d_in;
        logic [AW-1:0]    a_in;
        logic [1:0]       m_in;
        logic             s_in;
        logic             v_in;
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        if (k == 0) begin : g_src
            assign v_in = in_valid && in_ready;
            assign d_in = in_data;
            assign a_in = in_amt;
            assign m_in = in_mode;
            assign s_in = in_data[WIDTH-1];
        end else begin : g_src
            assign v_in = g_stage[k-1].valid_q;
            assign d_in = g_stage[k-1].data_q;
            assign a_in = g_stage[k-1].g_carry.amt_q;
            assign m_in = g_stage[k-1].g_carry.mode_q;
            assign s_in = g_stage[k-1].g_carry.sign_q;
        end

        // Stage data and valid: shift by 2^k when selected, hold on stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                data_q  <= a_in[0] ? shift_pow2(d_in, m_in, s_in, 1 << k) : d_in;
            end
        end

        // The last stage has no successor, so only earlier stages carry control.
        if (k < S - 1) begin : g_carry
            logic [AW-2:0] amt_q;
            logic [1:0]    mode_q;
            logic          sign_q;

            // Carry the unconsumed amount bits, mode and original sign forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    amt_q  <= '0;
                    mode_q <= 2'b00;
                    sign_q <= 1'b0;
                end else if (adv) begin
                    amt_q  <= a_in[AW-1:1];
                    mode_q <= m_in;
                    sign_q <= s_in;
                end
            end
        end
    end

    assign out_valid = g_stage[S-1].valid_q;
    assign out_data  = g_stage[S-1].data_q;
    assign out_zero  = out_valid && (out_data == '0);

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed plus random bench for barrel_shifter_pipe: an 8-bit instance with a
// scoreboard of expected results and a 4-bit instance for the legacy rotate.
module tb_barrel_shifter_pipe;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [7:0] in_data, out_data;
    logic [2:0] in_amt;
    logic [1:0] in_mode;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
    logic [3:0] in_data4, out_data4;
    logic [1:0] in_amt4;
    logic [1:0] in_mode4;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         rx_count = 0;
    logic [7:0] cur_exp  = 8'h00;
    bit         accepted = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    barrel_shifter_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    barrel_shifter_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_amt(in_amt4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_zero(out_zero4)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] x, input int a, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'b00:   r = (x << a) | (x >> (8 - a));
            2'b01:   r = (x >> a) | (x << (8 - a));
            2'b10:   r = x << a;
            default: r = 8'($signed(x) >>> a);
        endcase
        return r;
    endfunction

    // Output monitor: handshake rule, stall stability and in-order scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", {7'b0, in_ready}, {7'b0, (!out_valid || out_ready)});
            if (prev_stall) begin
                check("stall_valid", {7'b0, out_valid}, 8'h01);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                n_assert++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow: observed result %h expected none pending", out_data);
                end
                if (exp_q.size() > 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e);
                    check("sb_zero", {7'b0, out_zero}, {7'b0, (e == 8'h00)});
                end
                rx_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            accepted = 1'b1;
        end else begin
            accepted = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                        input logic [7:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        cur_exp  = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check(tag, 8'(exp_q.size()), 8'h00);
    endtask

    logic [7:0] t2_d[5] = '{8'h96, 8'h90, 8'h70, 8'hFF, 8'h80};
    logic [2:0] t2_a[5] = '{3'd3, 3'd2, 3'd2, 3'd7, 3'd1};
    logic [1:0] t2_m[5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [7:0] t2_e[5] = '{8'hD2, 8'hE4, 8'h1C, 8'h80, 8'h00};

    logic [7:0] bp_d[6] = '{8'h81, 8'h3C, 8'hF0, 8'h01, 8'hAA, 8'h7E};
    logic [2:0] bp_a[6] = '{3'd1, 3'd2, 3'd3, 3'd7, 3'd5, 3'd4};
    logic [1:0] bp_m[6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};

    initial begin
        int sent;
        int rx0;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_mode = 2'b00; out_ready = 1'b1;
        in_valid4 = 1'b0; in_data4 = 4'h0; in_amt4 = 2'd0; in_mode4 = 2'b00; out_ready4 = 1'b1;

        #12;
        check("rst_out_valid", {7'b0, out_valid}, 8'h00);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_zero", {7'b0, out_zero}, 8'h00);
        check("rst_in_ready", {7'b0, in_ready}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat latency: accepted cycle 0, visible cycle 3, gone cycle 4.
        beat(8'hA0, 3'd1, 2'b00, 8'h41);
        tick(); idle();
        check("lat_c1_valid", {7'b0, out_valid}, 8'h00);
        tick();
        check("lat_c2_valid", {7'b0, out_valid}, 8'h00);
        tick();
        check("lat_c3_valid", {7'b0, out_valid}, 8'h01);
        check("lat_c3_data", out_data, 8'h41);
        check("lat_c3_zero", {7'b0, out_zero}, 8'h00);
        tick();
        check("lat_c4_valid", {7'b0, out_valid}, 8'h00);

        // Back-to-back beats, results in cycles 3..7 with no bubbles.
        for (int c = 0; c < 9; c++) begin
            if (c < 5) beat(t2_d[c], t2_a[c], t2_m[c], t2_e[c]);
            else idle();
            tick();
            if (c < 5) check("b2b_accept", {7'b0, accepted}, 8'h01);
            if (c + 1 >= 3 && c + 1 <= 7) begin
                check("b2b_valid", {7'b0, out_valid}, 8'h01);
                check("b2b_data", out_data, t2_e[c - 2]);
                check("b2b_zero", {7'b0, out_zero}, {7'b0, (t2_e[c - 2] == 8'h00)});
            end else if (c + 1 == 8) begin
                check("b2b_empty", {7'b0, out_valid}, 8'h00);
            end
        end

        // Amount 0 in every mode, then ROL sweep of a single bit.
        for (int i = 0; i < 4; i++) begin
            beat(8'h5A, 3'd0, 2'(i), 8'h5A);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            beat(8'h01, 3'(i), 2'b00, 8'(1 << i));
            tick();
        end
        idle();
        drain("sweep_drain");

        // Backpressure: six beats with out_ready low for cycles 4..7.
        rx0  = rx_count;
        sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || exp_q.size() > 0); c++) begin
            out_ready = !(c >= 4 && c <= 7);
            if (sent < 6) beat(bp_d[sent], bp_a[sent], bp_m[sent],
                               model(bp_d[sent], int'(bp_a[sent]), bp_m[sent]));
            else idle();
            tick();
            if (accepted) sent++;
        end
        idle();
        out_ready = 1'b1;
        check("bp_sent", 8'(sent), 8'd6);
        check("bp_received", 8'(rx_count - rx0), 8'd6);
        check("bp_pending", 8'(exp_q.size()), 8'h00);

        // Random traffic against the reference model with random backpressure.
        rx0  = rx_count;
        sent = 0;
        for (int c = 0; c < 400 && (sent < 40 || exp_q.size() > 0); c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
                logic [7:0] d;
                logic [2:0] a;
                logic [1:0] m;
                d = 8'($urandom);
                a = 3'($urandom_range(0, 7));
                m = 2'($urandom_range(0, 3));
                beat(d, a, m, model(d, int'(a), m));
            end
            tick();
            if (accepted) begin
                sent++;
                idle();
            end
        end
        idle();
        out_ready = 1'b1;
        check("rand_sent", 8'(sent), 8'd40);
        check("rand_received", 8'(rx_count - rx0), 8'd40);
        check("rand_pending", 8'(exp_q.size()), 8'h00);

        // Mid-cycle reset with three beats in flight.
        beat(8'h11, 3'd1, 2'b00, model(8'h11, 1, 2'b00)); tick();
        beat(8'h22, 3'd2, 2'b01, model(8'h22, 2, 2'b01)); tick();
        beat(8'h33, 3'd3, 2'b10, model(8'h33, 3, 2'b10)); tick();
        idle();
        check("pre_rst_valid", {7'b0, out_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {7'b0, out_valid}, 8'h00);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_zero", {7'b0, out_zero}, 8'h00);
        check("mid_rst_in_ready", {7'b0, in_ready}, 8'h01);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_flushed", {7'b0, out_valid}, 8'h00);
        beat(8'h0F, 3'd4, 2'b01, 8'hF0);
        tick(); idle();
        check("post_rst_c1", {7'b0, out_valid}, 8'h00);
        tick();
        check("post_rst_c2", {7'b0, out_valid}, 8'h00);
        tick();
        check("post_rst_c3_valid", {7'b0, out_valid}, 8'h01);
        check("post_rst_c3_data", out_data, 8'hF0);
        tick();

        // Legacy 4-bit rotate-by-one on the WIDTH=4 instance, latency 2.
        in_valid4 = 1'b1; in_data4 = 4'b1010; in_amt4 = 2'd1; in_mode4 = 2'b00;
        check("w4_ready", {7'b0, in_ready4}, 8'h01);
        tick();
        in_data4 = 4'b0101;
        check("w4_c1_valid", {7'b0, out_valid4}, 8'h00);
        tick();
        in_valid4 = 1'b0;
        check("w4_c2_valid", {7'b0, out_valid4}, 8'h01);
        check("w4_c2_data", {4'b0, out_data4}, 8'h05);
        tick();
        check("w4_c3_valid", {7'b0, out_valid4}, 8'h01);
        check("w4_c3_data", {4'b0, out_data4}, 8'h0A);
        tick();
        check("w4_c4_valid", {7'b0, out_valid4}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
